// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding RV32I load/store responder with fixed wait states
//
// Purpose: word-organised data memory answering one load/store at a time.
//   A request is accepted in IDLE, held for WAIT_CYCLES wait states, committed
//   (store) or captured (load) on the edge entering RESP, and presented as a
//   registered response one cycle later until the initiator takes it.
// Ports:
//   clock, reset         - rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready  - request handshake (ready only in IDLE)
//   req_write            - 1 = store, 0 = load
//   req_addr             - byte address; wraps modulo the storage size
//   req_funct3           - RV32I load/store size/sign code
//   req_wdata            - right-aligned store data
//   rsp_valid/rsp_ready  - response handshake
//   rsp_rdata            - extended load data; 0 for stores and errors
//   rsp_err              - request rejected, storage untouched
// Configuration macro: DMEM_MISALIGN_CHECK_EN
//   defined   - misaligned half/word accesses are rejected with rsp_err
//   undefined - misaligned half/word accesses are forced to natural alignment
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state;
    logic [3:0]    wait_cnt;
    logic [AW+1:0] addr_q;
    logic [2:0]    funct3_q;
    logic          write_q;
    logic [31:0]   wdata_q;
    logic [31:0]   mem [DEPTH_WORDS];

    logic          accept;
    logic          enter_resp;
    logic [AW+1:0] cur_addr;
    logic [2:0]    cur_funct3;
    logic          cur_write;
    logic [31:0]   cur_wdata;
    logic [AW-1:0] idx;
    logic [1:0]    lo;
    logic          legal;
    logic          misalign;
    logic          access_err;
    logic [31:0]   word;
    logic [31:0]   shifted;
    logic [15:0]   half;
    logic [31:0]   load_val;
    logic [3:0]    be;
    logic [31:0]   wd_rep;
    logic [31:0]   new_word;
    logic          unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:AW+2];

    assign req_ready = (state == IDLE);
    assign accept    = req_valid & req_ready;

    // With zero wait states the accepting edge is also the commit edge, so the
    // access is decoded straight from the request inputs while in IDLE.
    assign enter_resp = (state == IDLE) ? (accept && (WAIT_CYCLES == 0))
                                        : ((state == WAIT) && (wait_cnt == 4'd1));

    assign cur_addr   = (state == IDLE) ? req_addr[AW+1:0] : addr_q;
    assign cur_funct3 = (state == IDLE) ? req_funct3       : funct3_q;
    assign cur_write  = (state == IDLE) ? req_write        : write_q;
    assign cur_wdata  = (state == IDLE) ? req_wdata        : wdata_q;
    assign idx        = cur_addr[AW+1:2];

    always_comb begin
        legal    = cur_write ? (cur_funct3 <= 3'd2)
                             : (cur_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
`ifdef DMEM_MISALIGN_CHECK_EN
        misalign = ((cur_funct3[1:0] == 2'b01) && cur_addr[0]) ||
                   ((cur_funct3[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00));
        lo       = cur_addr[1:0];
`else
        misalign = 1'b0;
        case (cur_funct3[1:0])
            2'b01:   lo = {cur_addr[1], 1'b0};
            2'b10:   lo = 2'b00;
            default: lo = cur_addr[1:0];
        endcase
`endif
        access_err = !legal || misalign;

        word    = mem[idx];
        shifted = word >> {lo, 3'b000};
        half    = lo[1] ? word[31:16] : word[15:0];
        case (cur_funct3)
            3'd0:    load_val = {{24{shifted[7]}}, shifted[7:0]};
            3'd1:    load_val = {{16{half[15]}}, half};
            3'd4:    load_val = {24'd0, shifted[7:0]};
            3'd5:    load_val = {16'd0, half};
            default: load_val = word;
        endcase

        case (cur_funct3[1:0])
            2'b00: begin
                be     = 4'b0001 << lo;
                wd_rep = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                be     = lo[1] ? 4'b1100 : 4'b0011;
                wd_rep = {2{cur_wdata[15:0]}};
            end
            default: begin
                be     = 4'b1111;
                wd_rep = cur_wdata;
            end
        endcase
        for (int b = 0; b < 4; b++) begin
            new_word[8*b +: 8] = be[b] ? wd_rep[8*b +: 8] : word[8*b +: 8];
        end
    end

    // Storage has no reset; gating on reset drops a store whose commit edge
    // coincides with reset being held.
    always_ff @(posedge clock) begin
        if (!reset && enter_resp && cur_write && !access_err) begin
            mem[idx] <= new_word;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            addr_q    <= '0;
            funct3_q  <= 3'd0;
            write_q   <= 1'b0;
            wdata_q   <= 32'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            if (enter_resp) begin
                rsp_rdata <= (cur_write || access_err) ? 32'd0 : load_val;
                rsp_err   <= access_err;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q   <= req_addr[AW+1:0];
                        funct3_q <= req_funct3;
                        write_q  <= req_write;
                        wdata_q  <= req_wdata;
                        wait_cnt <= 4'(WAIT_CYCLES);
                        state    <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    // First RESP cycle raises rsp_valid, giving WAIT_CYCLES+1
                    // cycles from accept to a visible response.
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
